// File: rtl/data_sram_bridge.sv
// Core data port to SRAM-like bus bridge: one outstanding access, IDLE/ADDR/DATA/DONE.
// Optional DATA-phase timeout abort enabled by defining DSB_TIMEOUT_EN.
module data_sram_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_enM,
  input  logic [3:0]  memwriteM,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedataM,
  output logic [31:0] readdataM,
  input  logic        longest_stall,
  output logic        d_stall,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  state_t      state, stateNext;
  logic [31:0] rdataQ;
  logic        reqComb, stallComb;
  logic        dataDone;
  logic        timeoutHit;

  assign dataDone = (state == DATA) && data_data_ok;

`ifdef DSB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic          errQ;

  // Counter is held at zero outside DATA, so it restarts on every entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      errQ <= 1'b0;
    end else begin
      if (state != DATA)      cnt <= '0;
      else if (!data_data_ok) cnt <= cnt + 1'b1;
      if (timeoutHit)         errQ <= 1'b1;
    end
  end

  assign timeoutHit = (state == DATA) && !data_data_ok && (cnt == LAST);
  assign err        = errQ;
`else
  assign timeoutHit = 1'b0;
  assign err        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      rdataQ <= '0;
    end else begin
      state <= stateNext;
      if (dataDone)        rdataQ <= data_rdata;
      else if (timeoutHit) rdataQ <= '0;
    end
  end

  always_comb begin
    stateNext = state;
    reqComb   = 1'b0;
    stallComb = 1'b0;
    case (state)
      IDLE: if (mem_enM) begin
        reqComb   = 1'b1;
        stallComb = 1'b1;
        stateNext = data_addr_ok ? DATA : ADDR;
      end
      ADDR: begin
        reqComb   = 1'b1;
        stallComb = 1'b1;
        if (data_addr_ok) stateNext = DATA;
      end
      DATA: begin
        if (data_data_ok)    stateNext = longest_stall ? DONE : IDLE;
        else if (timeoutHit) stateNext = IDLE;
        else                 stallComb = 1'b1;
      end
      DONE: if (!longest_stall) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    case (memwriteM)
      4'b1111:                            data_size = 2'd2;
      4'b0011, 4'b1100:                   data_size = 2'd1;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: data_size = 2'd0;
      default:                            data_size = 2'd2;
    endcase
  end

  // Outputs are gated by reset directly so they are quiet while rst is low.
  assign data_req   = rst && reqComb;
  assign d_stall    = rst && stallComb;
  assign readdataM  = !rst ? '0 : (dataDone ? data_rdata : rdataQ);
  assign data_addr  = dataadr;
  assign data_wdata = writedataM;
  assign data_wr    = |memwriteM;

endmodule

// File: tb/tb_data_sram_bridge.sv
// Directed bench for data_sram_bridge; timeout scenario runs when DSB_TIMEOUT_EN is defined.
module tb_data_sram_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_enM;
  logic [3:0]  memwriteM;
  logic [31:0] dataadr;
  logic [31:0] writedataM;
  logic [31:0] readdataM;
  logic        longest_stall;
  logic        d_stall;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  data_sram_bridge #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .mem_enM(mem_enM), .memwriteM(memwriteM),
    .dataadr(dataadr), .writedataM(writedataM), .readdataM(readdataM),
    .longest_stall(longest_stall), .d_stall(d_stall), .data_req(data_req),
    .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, then sit mid-cycle where inputs are driven.
  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic chkCtl(input string tag, input logic req, input logic stall);
    chk({tag, ".req"},   32'(data_req), 32'(req));
    chk({tag, ".stall"}, 32'(d_stall),  32'(stall));
  endtask

  initial begin
    rst = 1'b0; mem_enM = 1'b1; memwriteM = 4'b0000; dataadr = 32'h1000_0000;
    writedataM = 32'h0; longest_stall = 1'b0; data_addr_ok = 1'b1;
    data_data_ok = 1'b1; data_rdata = 32'h5555_5555;
    #1;
    chkCtl("rst", 1'b0, 1'b0);
    chk("rst.rdata", readdataM, 32'h0);
    chk("rst.err", 32'(err), 32'h0);
    tick;
    mem_enM = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
    tick;
    rst = 1'b1;
    tick;

    // Word load, minimum latency
    mem_enM = 1'b1; memwriteM = 4'b0000; dataadr = 32'h1000_0000; data_addr_ok = 1'b1;
    #1;
    chkCtl("ld.c0", 1'b1, 1'b1);
    chk("ld.size", 32'(data_size), 32'd2);
    chk("ld.wr", 32'(data_wr), 32'h0);
    chk("ld.addr", data_addr, 32'h1000_0000);
    tick;
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
    #1;
    chkCtl("ld.c1", 1'b0, 1'b0);
    chk("ld.rdata", readdataM, 32'hDEAD_BEEF);
    tick;
    mem_enM = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
    #1;
    chk("ld.hold", readdataM, 32'hDEAD_BEEF);
    chkCtl("ld.idle", 1'b0, 1'b0);
    tick;

    // Byte store, addr_ok delayed 3 cycles
    mem_enM = 1'b1; memwriteM = 4'b0100; writedataM = 32'h00AB_0000; dataadr = 32'h2000_0002;
    #1;
    chkCtl("st.c0", 1'b1, 1'b1);
    chk("st.wr", 32'(data_wr), 32'h1);
    chk("st.size", 32'(data_size), 32'd0);
    chk("st.wdata", data_wdata, 32'h00AB_0000);
    tick; #1; chkCtl("st.c1", 1'b1, 1'b1);
    tick; #1; chkCtl("st.c2", 1'b1, 1'b1);
    tick;
    data_addr_ok = 1'b1;
    #1; chkCtl("st.c3", 1'b1, 1'b1);
    tick;
    data_addr_ok = 1'b0;
    #1; chkCtl("st.c4", 1'b0, 1'b1);
    tick;
    data_data_ok = 1'b1; data_rdata = 32'h0;
    #1; chkCtl("st.c5", 1'b0, 1'b0);
    tick;
    mem_enM = 1'b0; data_data_ok = 1'b0; memwriteM = 4'b0000;
    tick;

    // Size decode for halfword / full-word stores
    memwriteM = 4'b1100; #1; chk("size.half", 32'(data_size), 32'd1);
    memwriteM = 4'b1111; #1; chk("size.word", 32'(data_size), 32'd2);
    memwriteM = 4'b0000;

    // Load completing under longest_stall -> DONE
    mem_enM = 1'b1; data_addr_ok = 1'b1; dataadr = 32'h1000_0004;
    tick;
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h1234_5678; longest_stall = 1'b1;
    #1;
    chk("done.c0", readdataM, 32'h1234_5678);
    chkCtl("done.c0", 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick;
      data_data_ok = (i == 1); data_rdata = 32'hFFFF_0000;
      #1;
      chkCtl("done.hold", 1'b0, 1'b0);
      chk("done.rdata", readdataM, 32'h1234_5678);
    end
    tick;
    longest_stall = 1'b0; data_data_ok = 1'b0;
    #1; chkCtl("done.exit", 1'b0, 1'b0);
    tick;
    // Back-in IDLE with mem_enM still high: next access issues now
    #1; chkCtl("done.reissue", 1'b1, 1'b1);
    mem_enM = 1'b0;
    tick;

    // Back-to-back: no request in the completion cycle, new one next cycle
    mem_enM = 1'b1; data_addr_ok = 1'b1;
    tick;
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hCAFE_0001;
    #1; chkCtl("b2b.c1", 1'b0, 1'b0);
    tick;
    data_data_ok = 1'b0; data_addr_ok = 1'b1;
    #1; chkCtl("b2b.c2", 1'b1, 1'b1);
    chk("b2b.rdata", readdataM, 32'hCAFE_0001);
    tick;
    data_addr_ok = 1'b0; mem_enM = 1'b0;
    #1; chkCtl("b2b.data", 1'b0, 1'b1);

    // Reset pulse in DATA, then stray data_ok
    rst = 1'b0;
    mem_enM = 1'b1;
    #1;
    chkCtl("rstmid", 1'b0, 1'b0);
    chk("rstmid.rdata", readdataM, 32'h0);
    tick;
    rst = 1'b1; mem_enM = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hAAAA_AAAA;
    #1;
    chkCtl("stray", 1'b0, 1'b0);
    chk("stray.rdata", readdataM, 32'h0);
    tick;
    data_data_ok = 1'b0;
    #1; chk("stray.after", readdataM, 32'h0);

`ifdef DSB_TIMEOUT_EN
    // Seed a nonzero captured value, then let a load time out
    mem_enM = 1'b1; data_addr_ok = 1'b1;
    tick;
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h7777_7777;
    tick;
    data_data_ok = 1'b0; data_addr_ok = 1'b1;
    tick;
    data_addr_ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1; chkCtl("to.wait", 1'b0, 1'b1);
      chk("to.err0", 32'(err), 32'h0);
      tick;
    end
    #1; chkCtl("to.hit", 1'b0, 1'b0);
    tick;
    mem_enM = 1'b0;
    #1;
    chk("to.err", 32'(err), 32'h1);
    chk("to.rdata", readdataM, 32'h0);
    chkCtl("to.idle", 1'b0, 1'b0);
    tick; tick;
    #1; chk("to.sticky", 32'(err), 32'h1);
`else
    #1; chk("err.tied", 32'(err), 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_sram_bridge.md
DATA_SRAM_BRIDGE -- requirements
Module: data_sram_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of DATA-state cycles before abort (used only under DSB_TIMEOUT_EN).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, the reset; asynchronous, active-low.
REQ-004 SHALL have port mem_enM, input, 1, the core data access request (M stage).
REQ-005 SHALL have port memwriteM, input, 4, the byte write enables; 0 means load.
REQ-006 SHALL have port dataadr, input, 32, the physical data address.
REQ-007 SHALL have port writedataM, input, 32, the store data.
REQ-008 SHALL have port readdataM, output, 32, the load data returned to the core.
REQ-009 SHALL have port longest_stall, input, 1, meaning the core pipeline is frozen by another source.
REQ-010 SHALL have port d_stall, output, 1, the stall request to the core hazard logic.
REQ-011 SHALL have port data_req, output, 1, the bus request.
REQ-012 SHALL have port data_wr, output, 1, meaning 1=write.
REQ-013 SHALL have port data_size, output, 2, the transfer size: 0=byte, 1=half, 2=word.
REQ-014 SHALL have ports data_addr and data_wdata, output, 32 each, the bus address and write data.
REQ-015 SHALL have ports data_addr_ok and data_data_ok, input, 1 each, the address-accepted and data-returned strobes.
REQ-016 SHALL have port data_rdata, input, 32, the bus read data.
REQ-017 SHALL have port err, output, 1, the sticky timeout flag.

Function
REQ-018 SHALL implement FSM states IDLE, ADDR, DATA, DONE.
REQ-019 SHALL drive data_req=1 when (IDLE & mem_enM) or ADDR, and 0 otherwise.
REQ-020 SHALL, from IDLE with mem_enM, go to DATA if data_addr_ok=1 in the same cycle, else to ADDR.
REQ-021 SHALL hold ADDR until data_addr_ok=1, then go to DATA.
REQ-022 SHALL ignore data_data_ok outside DATA.
REQ-023 SHALL, in DATA with data_data_ok=1, capture data_rdata into rdata_q, then go to DONE if longest_stall=1, else to IDLE.
REQ-024 SHALL hold DONE while longest_stall=1, with no new request issued, and go to IDLE when longest_stall=0.
REQ-025 SHALL drive d_stall=1 when (IDLE & mem_enM) or ADDR or (DATA & !data_data_ok), and 0 otherwise, including in DONE.
REQ-026 SHALL set readdataM = data_rdata in the DATA & data_data_ok cycle, else rdata_q.
REQ-027 SHALL pass data_addr=dataadr, data_wdata=writedataM and data_wr=|memwriteM through combinationally; the core holds them stable while d_stall=1.
REQ-028 SHALL derive data_size from memwriteM: 1111→2; 0011 or 1100→1; one-hot→0; loads use 2.
REQ-029 SHALL give a minimum load latency of 2 cycles (addr_ok in issue cycle, data_ok in the next cycle), with d_stall high for exactly 1 cycle.
REQ-030 SHALL never start a new request in the cycle data_data_ok completes; back-to-back accesses issue from IDLE on the following cycle.

Reset
REQ-031 SHALL, while rst=0, force state=IDLE, rdata_q=0, err=0 and timeout counter=0; readdataM=0, d_stall=0 and data_req=0 regardless of inputs.
REQ-032 SHALL drop an access in flight when reset is asserted mid-transaction; any late data_data_ok after release is ignored in IDLE.

Configuration
REQ-033 SHALL, with DSB_TIMEOUT_EN defined, count DATA cycles (reset on entry); when the count reaches TIMEOUT_CYCLES without data_data_ok, go to IDLE, set rdata_q=0, release d_stall and set err=1 (sticky until reset).
REQ-034 SHALL, without DSB_TIMEOUT_EN, omit the counter, wait indefinitely in DATA and tie err=0.

Verification
REQ-035 SHALL cover: word load at 0x1000_0000, addr_ok at cycle 0, data_ok at cycle 1 with rdata 0xDEAD_BEEF -> d_stall high 1 cycle, readdataM=0xDEAD_BEEF, data_size=2.
REQ-036 SHALL cover: byte store memwriteM=0100, addr_ok delayed 3 cycles -> data_req held 4 cycles, data_wr=1, data_size=0, d_stall high until data_ok.
REQ-037 SHALL cover: load completing with longest_stall=1 for 5 cycles -> FSM in DONE, data_req=0 throughout, readdataM stable at the captured value, d_stall=0.
REQ-038 SHALL cover: rst pulsed low in DATA, then a stray data_data_ok after release -> IDLE, readdataM=0, no stall.
REQ-039 SHALL cover: with DSB_TIMEOUT_EN and TIMEOUT_CYCLES=4, data_ok never arrives -> after 4 DATA cycles d_stall=0, err=1, readdataM=0.
